// File: rtl/amp_i2s_receiver.sv
// Oversampled I2S receiver: stereo deserialiser with slot-length framing lock.
// Define AMP_I2S_RX_LJ_EN for left-justified instead of Philips one-bit-delay.
module amp_i2s_receiver #(
    parameter int WIDTH       = 16,
    parameter int SLOTS       = 32,
    parameter int LOCK_FRAMES = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic             clk_in,
    input  logic             resetb,
    input  logic             i2s_bck,
    input  logic             i2s_ws,
    input  logic             i2s_d0,
    output logic [WIDTH-1:0] left_pcm,
    output logic [WIDTH-1:0] right_pcm,
    output logic             sample_valid,
    output logic             audio_locked
);

    localparam int GW = $clog2(2*LOCK_FRAMES+1);
    localparam int TW = $clog2(TIMEOUT+1);
`ifdef AMP_I2S_RX_LJ_EN
    localparam int SRW = SLOTS;
`else
    localparam int SRW = SLOTS-1;
`endif

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    logic [SYNC_STAGES-1:0] r_bck_sy, r_ws_sy, r_d0_sy;
    logic                   r_bck_prev, r_ws_prev;
    logic [SRW-1:0]         r_sr;
    logic [5:0]             r_bit_cnt;
    logic [WIDTH-1:0]       r_left_hold;
    logic                   r_left_ok;
    logic [TW-1:0]          r_idle;
    state_t                 r_state, w_state_nxt;
    logic [GW-1:0]          r_good, w_good_nxt;

    logic             w_bck_rise, w_ws_s, w_d0_s, w_edge, w_timeout;
    logic             w_slot_ok, w_emit;
    logic [SLOTS-1:0] w_shift;
    logic [WIDTH-1:0] w_kept;
    logic [5:0]       w_cnt_rst;

    assign w_bck_rise = r_bck_sy[SYNC_STAGES-1] & ~r_bck_prev;
    assign w_ws_s     = r_ws_sy[SYNC_STAGES-1];
    assign w_d0_s     = r_d0_sy[SYNC_STAGES-1];
    assign w_edge     = w_bck_rise & (w_ws_s != r_ws_prev);
    assign w_timeout  = (r_idle == TW'(TIMEOUT));

`ifdef AMP_I2S_RX_LJ_EN
    // Transition bit is the MSB of the new slot, so the ended word is sr.
    assign w_shift   = {r_sr[SRW-2:0], w_d0_s};
    assign w_kept    = r_sr[SLOTS-1 -: WIDTH];
    assign w_slot_ok = ({1'b0, r_bit_cnt} == 7'(SLOTS));
    assign w_cnt_rst = 6'd1;
`else
    assign w_shift   = {r_sr, w_d0_s};
    assign w_kept    = w_shift[SLOTS-1 -: WIDTH];
    assign w_slot_ok = ({1'b0, r_bit_cnt} + 7'd1 == 7'(SLOTS));
    assign w_cnt_rst = 6'd0;
`endif

    assign w_emit = w_edge & r_ws_prev & w_slot_ok & r_left_ok
                  & (r_state == LOCKED) & ~w_timeout;

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_bck_sy    <= '0;
            r_ws_sy     <= '0;
            r_d0_sy     <= '0;
            r_bck_prev  <= 1'b0;
            r_ws_prev   <= 1'b0;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_left_hold <= '0;
            r_left_ok   <= 1'b0;
            r_idle      <= '0;
        end else begin
            r_bck_sy   <= {r_bck_sy[SYNC_STAGES-2:0], i2s_bck};
            r_ws_sy    <= {r_ws_sy[SYNC_STAGES-2:0], i2s_ws};
            r_d0_sy    <= {r_d0_sy[SYNC_STAGES-2:0], i2s_d0};
            r_bck_prev <= r_bck_sy[SYNC_STAGES-1];
            if (w_bck_rise)
                r_idle <= '0;
            else if (!w_timeout)
                r_idle <= r_idle + 1'b1;
            if (w_bck_rise) begin
                r_sr      <= w_shift[SRW-1:0];
                r_ws_prev <= w_ws_s;
                if (w_edge)
                    r_bit_cnt <= w_cnt_rst;
                else if (r_bit_cnt != 6'd63)
                    r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_edge && !r_ws_prev) begin
                r_left_hold <= w_kept;
                r_left_ok   <= w_slot_ok;
            end
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            r_state      <= HUNT;
            r_good       <= '0;
            left_pcm     <= '0;
            right_pcm    <= '0;
            sample_valid <= 1'b0;
            audio_locked <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good       <= w_good_nxt;
            sample_valid <= w_emit;
            audio_locked <= (w_state_nxt == LOCKED);
            if (w_emit) begin
                left_pcm  <= r_left_hold;
                right_pcm <= w_kept;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        if (w_timeout) begin
            w_state_nxt = HUNT;
            w_good_nxt  = '0;
        end else if (w_edge) begin
            unique case (r_state)
                HUNT: begin
                    w_state_nxt = CHECK;
                    w_good_nxt  = '0;
                end
                CHECK: begin
                    if (!w_slot_ok)
                        w_good_nxt = '0;
                    else if (r_good == GW'(2*LOCK_FRAMES-1)) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = '0;
                    end else
                        w_good_nxt = r_good + 1'b1;
                end
                LOCKED: begin
                    if (!w_slot_ok) begin
                        w_state_nxt = CHECK;
                        w_good_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_good_nxt  = '0;
                end
            endcase
        end
    end

endmodule
